pool_engine: RTL and testbench

POOL_ENGINE -- requirements
Module: pool_engine

---
 rtl/pool_engine_if.sv | 37 +++
 rtl/pool_engine.sv | 134 +++++++++++++
 tb/tb_pool_engine.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pool_engine_if.sv
// pool_engine_if: control, pool-buffer read and conv-buffer write signals of the 2x2 max-pool engine.
//   state[3:0]    layer state code (POOL1 4'b0011, POOL2 4'b0101, POOL3 4'b0111)
//   start         one-cycle launch pulse
//   busy, done    pass in progress / one-cycle completion pulse
//   rd_en, rd_y, rd_x, rd_c, rd_updown   pool-buffer read request
//   rd_data[43:0] pixel pair returned one cycle after rd_en ([21:0] even x, [43:22] odd x)
//   wr_en, wr_y, wr_x, wr_c, wr_data     conv-buffer write of one pooled value
// The master drives state/start/rd_data; the slave is the engine.
interface pool_engine_if;
    logic [3:0]  state;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [5:0]  rd_y;
    logic [5:0]  rd_x;
    logic [5:0]  rd_c;
    logic        rd_updown;
    logic [43:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_y;
    logic [4:0]  wr_x;
    logic [5:0]  wr_c;
    logic [21:0] wr_data;

    modport master (
        output state, start, rd_data,
        input  busy, done, rd_en, rd_y, rd_x, rd_c, rd_updown,
        input  wr_en, wr_y, wr_x, wr_c, wr_data
    );

    modport slave (
        input  state, start, rd_data,
        output busy, done, rd_en, rd_y, rd_x, rd_c, rd_updown,
        output wr_en, wr_y, wr_x, wr_c, wr_data
    );
endinterface

// File: rtl/pool_engine.sv
// pool_engine: 2x2 max-pool engine, reads upper/lower pixel pairs and writes the signed window maximum.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pool_engine_if slave: state/start in, busy/done out, read request out with
//          rd_data back one cycle later, one pooled write out per output position
module pool_engine (
    input  logic         clk,
    input  logic         rst_n,
    pool_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;

    fsm_t               fsm;
    logic [5:0]         hw_last;
    logic [5:0]         c_last;
    logic               p1_v;
    logic               p1_ud;
    logic [4:0]         p1_y;
    logic [4:0]         p1_x;
    logic [5:0]         p1_c;
    logic signed [21:0] up_e;
    logic signed [21:0] up_o;
    logic signed [21:0] in_e;
    logic signed [21:0] in_o;
    logic signed [21:0] m_up;
    logic signed [21:0] m_lo;
    logic signed [21:0] m_all;
    logic               pool_code;
    logic               x_end;
    logic               y_end;
    logic               last_pos;
    logic               wr_now;

    always_comb begin
        pool_code = bus.state == 4'b0011 || bus.state == 4'b0101 || bus.state == 4'b0111;
        x_end     = bus.rd_x == hw_last;
        y_end     = bus.rd_y == hw_last;
        last_pos  = x_end && y_end && bus.rd_c == c_last;
        in_e      = bus.rd_data[21:0];
        in_o      = bus.rd_data[43:22];
        m_up      = up_e > up_o ? up_e : up_o;
        m_lo      = in_e > in_o ? in_e : in_o;
        m_all     = m_up > m_lo ? m_up : m_lo;
        // p1 marks the read whose data is on rd_data this cycle; the lower row completes a window
        wr_now    = p1_v && p1_ud;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm           <= IDLE;
            hw_last       <= '0;
            c_last        <= '0;
            p1_v          <= 1'b0;
            p1_ud         <= 1'b0;
            p1_y          <= '0;
            p1_x          <= '0;
            p1_c          <= '0;
            up_e          <= '0;
            up_o          <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.rd_updown <= 1'b0;
            bus.rd_y      <= '0;
            bus.rd_x      <= '0;
            bus.rd_c      <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_y      <= '0;
            bus.wr_x      <= '0;
            bus.wr_c      <= '0;
            bus.wr_data   <= '0;
        end else begin
            p1_v  <= bus.rd_en;
            p1_ud <= bus.rd_updown;
            p1_y  <= bus.rd_y[4:0];
            p1_x  <= bus.rd_x[4:0];
            p1_c  <= bus.rd_c;
            if (p1_v && !p1_ud) begin
                up_e <= in_e;
                up_o <= in_o;
            end
            bus.wr_en   <= wr_now;
            bus.wr_y    <= wr_now ? p1_y : '0;
            bus.wr_x    <= wr_now ? p1_x : '0;
            bus.wr_c    <= wr_now ? p1_c : '0;
            bus.wr_data <= wr_now ? m_all : '0;
            case (fsm)
                IDLE: begin
                    if (bus.start && pool_code) begin
                        fsm           <= RUN;
                        bus.busy      <= 1'b1;
                        bus.rd_en     <= 1'b1;
                        bus.rd_updown <= 1'b0;
                        bus.rd_y      <= '0;
                        bus.rd_x      <= '0;
                        bus.rd_c      <= '0;
                        hw_last       <= bus.state == 4'b0011 ? 6'd15 : bus.state == 4'b0101 ? 6'd7 : 6'd3;
                        c_last        <= bus.state == 4'b0011 ? 6'd15 : bus.state == 4'b0101 ? 6'd31 : 6'd63;
                    end
                end
                RUN: begin
                    if (!bus.rd_updown) begin
                        bus.rd_updown <= 1'b1;
                    end else if (last_pos) begin
                        fsm           <= DRAIN;
                        bus.rd_en     <= 1'b0;
                        bus.rd_updown <= 1'b0;
                        bus.rd_y      <= '0;
                        bus.rd_x      <= '0;
                        bus.rd_c      <= '0;
                    end else begin
                        bus.rd_updown <= 1'b0;
                        bus.rd_x      <= x_end ? '0 : bus.rd_x + 6'd1;
                        bus.rd_y      <= !x_end ? bus.rd_y : y_end ? '0 : bus.rd_y + 6'd1;
                        bus.rd_c      <= x_end && y_end ? bus.rd_c + 6'd1 : bus.rd_c;
                    end
                end
                DRAIN: begin
                    // only the final window's write can appear while draining
                    if (bus.wr_en) begin
                        fsm      <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    fsm      <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: randomized self-checking bench for pool_engine against a window-max reference model.
module tb_pool_engine;
    localparam logic [3:0] POOL1 = 4'b0011;
    localparam logic [3:0] POOL2 = 4'b0101;
    localparam logic [3:0] POOL3 = 4'b0111;
    localparam logic signed [21:0] MINV = 22'sh200000;

    typedef struct packed {
        logic       busy, done, rd_en, rd_ud;
        logic [5:0] rc, ry, rx;
        logic       wr_en;
        logic [5:0] wc;
        logic [4:0] wy, wx;
        logic [21:0] wd;
    } outs_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    int                 checks = 0;
    int                 errors = 0;
    logic signed [21:0] img [0:65535];
    logic signed [21:0] wd0;
    logic signed [21:0] wd1;
    logic [15:0]        last_idx;
    int                 last_n;
    int                 last_done;

    pool_engine_if bus ();
    pool_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int ad(input int c, input int r, input int x);
        return c * 1024 + r * 32 + x;
    endfunction

    // pool buffer: a pixel pair from the addressed input row, one cycle after the request
    always @(posedge clk)
        bus.rd_data <= bus.rd_en ?
            {img[ad(int'(bus.rd_c), 2 * int'(bus.rd_y) + int'(bus.rd_updown), 2 * int'(bus.rd_x) + 1)],
             img[ad(int'(bus.rd_c), 2 * int'(bus.rd_y) + int'(bus.rd_updown), 2 * int'(bus.rd_x))]} : '0;

    function automatic logic signed [21:0] winmax(input int c, input int y, input int x);
        logic signed [21:0] m = img[ad(c, 2 * y, 2 * x)];
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (img[ad(c, 2 * y + dy, 2 * x + dx)] > m) m = img[ad(c, 2 * y + dy, 2 * x + dx)];
        return m;
    endfunction

    // expected outputs k cycles after start is accepted, for a pass of T positions on an hw x hw grid
    function automatic outs_t model(input int k, input int T, input int hw);
        outs_t e = '0;
        int p;
        e.busy = k <= 2 * T + 3;
        e.done = k == 2 * T + 3;
        if (k >= 1 && k <= 2 * T) begin
            p       = (k - 1) / 2;
            e.rd_en = 1'b1;
            e.rd_ud = (k - 1) % 2 == 1;
            e.rx    = 6'(p % hw);
            e.ry    = 6'((p / hw) % hw);
            e.rc    = 6'(p / (hw * hw));
        end
        if (k >= 4 && k % 2 == 0 && (k - 4) / 2 < T) begin
            p       = (k - 4) / 2;
            e.wr_en = 1'b1;
            e.wx    = 5'(p % hw);
            e.wy    = 5'((p / hw) % hw);
            e.wc    = 6'(p / (hw * hw));
            e.wd    = winmax(p / (hw * hw), (p / hw) % hw, p % hw);
        end
        return e;
    endfunction

    task automatic check(input string tag, input int k, input outs_t e);
        outs_t o;
        o = {bus.busy, bus.done, bus.rd_en, bus.rd_updown, bus.rd_c, bus.rd_y, bus.rd_x,
             bus.wr_en, bus.wr_c, bus.wr_y, bus.wr_x, bus.wr_data};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s k=%0d got %h exp %h", tag, k, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // called at a falling edge; start is sampled on the next rising edge
    task automatic launch(input logic [3:0] st);
        bus.state = st;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_pass(input logic [3:0] st, input int abort_at, input int chg_k, input int poke_k);
        int hw, T, n, nd;
        hw = st == POOL1 ? 16 : st == POOL2 ? 8 : 4;
        T  = hw * hw * (st == POOL1 ? 16 : st == POOL2 ? 32 : 64);
        n  = 0;
        nd = 0;
        launch(st);
        for (int k = 1; k <= 2 * T + 4; k++) begin
            check("pass", k, model(k, T, hw));
            nd += int'(bus.done);
            if (bus.wr_en) begin
                if (n == 0) wd0 = bus.wr_data;
                if (n == 1) wd1 = bus.wr_data;
                last_idx = {bus.wr_c, bus.wr_y, bus.wr_x};
                n++;
                if (n == abort_at) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check("reset_mid", k + 1, '0);
                    nd += int'(bus.done);
                    rst_n = 1'b1;
                    last_n = n;
                    last_done = nd;
                    return;
                end
            end
            bus.start = k == poke_k;
            if (k == chg_k) bus.state = POOL2;
            @(negedge clk);
        end
        last_n = n;
        last_done = nd;
    endtask

    task automatic fill_random();
        int r;
        for (int i = 0; i < 65536; i++) begin
            r = $urandom_range(0, 7);
            img[i] = r == 0 ? MINV : r == 1 ? 22'sh1FFFFF : 22'($urandom);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.state = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset", 0, '0);

        // counting pattern; start lands on the first edge with reset released
        for (int c = 0; c < 64; c++)
            for (int r = 0; r < 8; r++)
                for (int x = 0; x < 8; x++)
                    img[ad(c, r, x)] = 22'(c * 16 + r * 4 + x);
        rst_n = 1'b1;
        run_pass(POOL3, -1, -1, -1);
        check_int("pool3_writes", last_n, 1024);
        check_int("pool3_done", last_done, 1);
        check_int("pool3_last_idx", int'(last_idx), int'({6'd63, 5'd3, 5'd3}));

        // random pixels with a mixed-sign window (incl. minimum) and an all-equal window
        fill_random();
        img[ad(0, 0, 0)] = -22'sd5;
        img[ad(0, 0, 1)] = -22'sd2;
        img[ad(0, 1, 0)] = -22'sd9;
        img[ad(0, 1, 1)] = MINV;
        img[ad(0, 0, 2)] = 22'sd7;
        img[ad(0, 0, 3)] = 22'sd7;
        img[ad(0, 1, 2)] = 22'sd7;
        img[ad(0, 1, 3)] = 22'sd7;
        run_pass(POOL3, -1, -1, 2 * 1024 + 3);
        check_int("win_mixed", int'(wd0), -2);
        check_int("win_equal", int'(wd1), 7);
        check_int("rand_writes", last_n, 1024);

        // start with a non-pool state code is ignored
        launch(4'b0010);
        for (int k = 1; k <= 6; k++) begin
            check("bad_state", k, '0);
            @(negedge clk);
        end

        // start pulsed while busy is ignored
        fill_random();
        run_pass(POOL2, -1, -1, 101);
        check_int("pool2_writes", last_n, 2048);
        check_int("pool2_done", last_done, 1);

        // reset at write 100, then restart at once with a mid-pass state change
        fill_random();
        run_pass(POOL1, 100, -1, -1);
        check_int("abort_done", last_done, 0);
        run_pass(POOL1, -1, 3001, -1);
        check_int("pool1_writes", last_n, 4096);
        check_int("pool1_done", last_done, 1);
        check_int("pool1_last_idx", int'(last_idx), int'({6'd15, 5'd15, 5'd15}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
